ghost_move_scheduler: RTL and testbench

- Time-multiplexes one shared ghost next-location datapath and its 4-port maze-wall ROM across NUM_GHOSTS ghosts.
- On every MOVE_DIV-th frame tick, it steps each ghost in index order: presents current/target position, waits out ROM latency, captures nextPos, validates it, commits it.
- Owns the ghost position registers. Sits between the game-state controller (targets, frame tick, start) and the renderer/collision logic (positions).

---
 rtl/ghost_pkg.sv | 32 +++
 rtl/ghost_move_scheduler_if.sv | 21 ++
 rtl/move_validator.sv | 31 +++
 rtl/ghost_move_scheduler.sv | 121 ++++++++++++
 tb/tb_ghost_move_scheduler.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ghost_pkg.sv
// Shared ghost movement types: position layout, maze bounds, scheduler states.
// Positions are packed as row*32 + col.
package ghost_pkg;

    localparam int POS_W     = 10;
    localparam int COL_W     = 5;
    localparam int ROW_W     = POS_W - COL_W;
    localparam int D_W       = POS_W - 4;
    localparam int MAZE_COLS = 22;
    localparam int MAZE_ROWS = 32;

    typedef logic [POS_W-1:0] pos_t;
    typedef logic [COL_W-1:0] col_t;
    typedef logic [ROW_W-1:0] row_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        COMMIT,
        DONE
    } sched_state_t;

    function automatic col_t pos_col(input pos_t p);
        return p[COL_W-1:0];
    endfunction

    function automatic row_t pos_row(input pos_t p);
        return p[POS_W-1:COL_W];
    endfunction

endpackage

// File: rtl/ghost_move_scheduler_if.sv
// Link between the scheduler and the shared next-location datapath.
// The scheduler presents a ghost, the datapath answers with its next position.
interface ghost_move_scheduler_if;

    ghost_pkg::pos_t nl_curr_pos;
    ghost_pkg::pos_t nl_target_pos;
    ghost_pkg::pos_t nl_next_pos;

    modport master (
        output nl_curr_pos,
        output nl_target_pos,
        input  nl_next_pos
    );

    modport slave (
        input  nl_curr_pos,
        input  nl_target_pos,
        output nl_next_pos
    );

endinterface

// File: rtl/move_validator.sv
// Accepts a move only if it lands inside the maze and is one orthogonal step.
// Row/col deltas are taken at full width so edge wrap-around is rejected.
module move_validator
    import ghost_pkg::*;
(
    input  pos_t curr,
    input  pos_t next,
    output logic valid
);

    logic signed [D_W-1:0] drow;
    logic signed [D_W-1:0] dcol;
    logic [D_W-1:0] arow;
    logic [D_W-1:0] acol;
    logic [D_W-1:0] ncol;
    logic [D_W-1:0] nrow;
    logic in_range;

    always_comb begin
        ncol = D_W'(pos_col(next));
        nrow = D_W'(pos_row(next));
        drow = nrow - D_W'(pos_row(curr));
        dcol = ncol - D_W'(pos_col(curr));
        arow = drow[D_W-1] ? D_W'(-drow) : D_W'(drow);
        acol = dcol[D_W-1] ? D_W'(-dcol) : D_W'(dcol);
        in_range = (ncol < D_W'(MAZE_COLS))
                && (nrow < D_W'(MAZE_ROWS));
        valid = in_range && ((arow + acol) == D_W'(1));
    end

endmodule

// File: rtl/ghost_move_scheduler.sv
// Steps every ghost through one shared next-location datapath each movement
// round, validating and committing the chosen positions in index order.
module ghost_move_scheduler
    import ghost_pkg::*;
#(
    parameter int NUM_GHOSTS = 4,
    parameter int ROM_LAT    = 1,
    parameter int MOVE_DIV   = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        frame_tick,
    input  logic                        start_game,
    input  logic                        freeze,
    input  logic [NUM_GHOSTS*POS_W-1:0] home_pos,
    input  logic [NUM_GHOSTS*POS_W-1:0] target_pos,
    ghost_move_scheduler_if.master      nl,
    output logic [NUM_GHOSTS*POS_W-1:0] ghost_pos,
    output logic                        busy,
    output logic                        round_done,
    output logic                        overrun
);

    localparam int IW = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam int DW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [IW-1:0] LAST      = IW'(NUM_GHOSTS - 1);
    localparam logic [DW-1:0] DIV_TOP   = DW'(MOVE_DIV - 1);
    localparam logic [1:0]    WAIT_LOAD = 2'(ROM_LAT - 1);

    sched_state_t  state;
    logic [IW-1:0] idx;
    logic [DW-1:0] div;
    logic [1:0]    wait_cnt;
    logic          pending;
    logic          trig;
    logic          valid;
    pos_t          pos_q [NUM_GHOSTS];

    assign trig       = frame_tick && !freeze && (div == DIV_TOP);
    assign busy       = (state != IDLE);
    assign round_done = (state == DONE);

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_out
        assign ghost_pos[g*POS_W +: POS_W] = pos_q[g];
    end

    move_validator u_val (
        .curr  (nl.nl_curr_pos),
        .next  (nl.nl_next_pos),
        .valid (valid)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= IDLE;
            idx              <= '0;
            div              <= '0;
            wait_cnt         <= '0;
            pending          <= 1'b0;
            overrun          <= 1'b0;
            nl.nl_curr_pos   <= '0;
            nl.nl_target_pos <= '0;
            for (int g = 0; g < NUM_GHOSTS; g++) pos_q[g] <= '0;
        end else if (start_game) begin
            state    <= IDLE;
            idx      <= '0;
            div      <= '0;
            wait_cnt <= '0;
            pending  <= 1'b0;
            overrun  <= 1'b0;
            for (int g = 0; g < NUM_GHOSTS; g++)
                pos_q[g] <= home_pos[g*POS_W +: POS_W];
        end else begin
            if (frame_tick && !freeze)
                div <= trig ? '0 : div + DW'(1);
            unique case (state)
                IDLE: begin
                    if (trig) begin
                        state <= ISSUE;
                        idx   <= '0;
                    end
                end
                ISSUE: begin
                    nl.nl_curr_pos   <= pos_q[idx];
                    nl.nl_target_pos <= target_pos[idx*POS_W +: POS_W];
                    wait_cnt         <= WAIT_LOAD;
                    state            <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) state <= COMMIT;
                    else wait_cnt <= wait_cnt - 2'd1;
                end
                COMMIT: begin
                    if (valid) pos_q[idx] <= nl.nl_next_pos;
                    if (idx == LAST) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + IW'(1);
                        state <= ISSUE;
                    end
                end
                DONE: begin
                    // a queued round (or a fresh trigger) starts back to back
                    if (pending || trig) begin
                        state <= ISSUE;
                        idx   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                    pending <= pending && trig;
                end
                default: state <= IDLE;
            endcase
            if (trig && (state inside {ISSUE, WAIT, COMMIT})) begin
                if (pending) overrun <= 1'b1;
                else pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ghost_move_scheduler.sv
// Bench for ghost_move_scheduler: directed scenarios plus random traffic,
// all compared cycle by cycle against a schedule-level reference model.
module tb_ghost_move_scheduler;
    import ghost_pkg::*;

    localparam int NG   = 4;
    localparam int LAT  = 1;
    localparam int DIV  = 8;
    localparam int RLEN = NG * (LAT + 2);
    localparam int PW   = NG * POS_W;

    localparam logic [PW-1:0] HOME1 = {10'h2A5, 10'h2A4, 10'h2A3, 10'h2A2};
    localparam logic [PW-1:0] EXP2  = {10'h2A6, 10'h2A5, 10'h2A4, 10'h2A3};
    localparam logic [PW-1:0] HOME3 = {10'h2A5, 10'h2A3, 10'h3E0, 10'h035};
    localparam logic [PW-1:0] TGT3  = {10'd4, 10'd2, 10'd2, 10'd0};
    localparam logic [PW-1:0] EXP3  = {10'h2A5, 10'h2C3, 10'h3E0, 10'h035};

    logic clk = 1'b0;
    logic reset_n, frame_tick, start_game, freeze;
    logic [PW-1:0] home_pos, target_pos, ghost_pos;
    logic busy, round_done, overrun;

    ghost_move_scheduler_if nl();

    ghost_move_scheduler #(
        .NUM_GHOSTS (NG),
        .ROM_LAT    (LAT),
        .MOVE_DIV   (DIV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .start_game (start_game),
        .freeze     (freeze),
        .home_pos   (home_pos),
        .target_pos (target_pos),
        .nl         (nl),
        .ghost_pos  (ghost_pos),
        .busy       (busy),
        .round_done (round_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // step chosen by the datapath, keyed on the low target bits
    function automatic int delta(input logic [2:0] t);
        case (t)
            3'd0: return 1;
            3'd1: return -1;
            3'd2: return 32;
            3'd3: return -32;
            3'd4: return 5;
            3'd5: return 0;
            3'd6: return 33;
            default: return 31;
        endcase
    endfunction

    always @(posedge clk)
        nl.nl_next_pos <= pos_t'(int'(nl.nl_curr_pos)
                        + delta(nl.nl_target_pos[2:0]));

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    int   m_c = 0;
    int   m_s = -1000;
    int   m_div = 0;
    bit   m_pend = 0;
    bit   m_ovr = 0;
    int   m_pos [NG];
    logic [2:0] m_tt [NG];

    function automatic bit move_ok(input int cur, input int nxt);
        int cr, cc, nr, nc, dr, dc;
        cr = cur / 32; cc = cur % 32;
        nr = nxt / 32; nc = nxt % 32;
        dr = (nr > cr) ? nr - cr : cr - nr;
        dc = (nc > cc) ? nc - cc : cc - nc;
        return (nc < MAZE_COLS) && (nr < MAZE_ROWS) && (dr + dc == 1);
    endfunction

    function automatic logic [PW-1:0] pack_pos();
        logic [PW-1:0] r;
        for (int g = 0; g < NG; g++) r[g*POS_W +: POS_W] = pos_t'(m_pos[g]);
        return r;
    endfunction

    task automatic model_step();
        int k, i, ph, nxt;
        bit act, trg;
        if (!reset_n) begin
            for (int g = 0; g < NG; g++) m_pos[g] = 0;
            m_div = 0; m_pend = 0; m_ovr = 0; m_s = -1000;
        end else if (start_game) begin
            for (int g = 0; g < NG; g++)
                m_pos[g] = int'(home_pos[g*POS_W +: POS_W]);
            m_div = 0; m_pend = 0; m_ovr = 0; m_s = -1000;
        end else begin
            trg = frame_tick && !freeze && (m_div == DIV - 1);
            if (frame_tick && !freeze) m_div = (m_div + 1) % DIV;
            k = m_c - m_s;
            act = (k >= 0) && (k <= RLEN);
            if (act && k < RLEN) begin
                i  = k / (LAT + 2);
                ph = k % (LAT + 2);
                if (ph == 0) m_tt[i] = target_pos[i*POS_W +: 3];
                if (ph == LAT + 1) begin
                    nxt = (m_pos[i] + delta(m_tt[i]) + 1024) % 1024;
                    if (move_ok(m_pos[i], nxt)) m_pos[i] = nxt;
                end
            end
            if (!act) begin
                if (trg) m_s = m_c + 1;
            end else if (k == RLEN) begin
                if (m_pend) begin
                    m_s = m_c + 1;
                    m_pend = trg;
                end else if (trg) begin
                    m_s = m_c + 1;
                end
            end else if (trg) begin
                if (m_pend) m_ovr = 1;
                else m_pend = 1;
            end
        end
        m_c++;
    endtask

    logic [PW-1:0] nxt_home, nxt_tgt;
    bit obs_done, obs_busy;

    task automatic cyc(input bit ft, input bit fr, input bit sg, input bit rn);
        int k;
        @(negedge clk);
        k = m_c - m_s;
        obs_done = round_done;
        obs_busy = busy;
        chk("pos", 64'(ghost_pos), 64'(pack_pos()));
        chk("busy", 64'(busy), 64'(k >= 0 && k <= RLEN));
        chk("done", 64'(round_done), 64'(k == RLEN));
        chk("ovr", 64'(overrun), 64'(m_ovr));
        frame_tick = ft; freeze = fr; start_game = sg; reset_n = rn;
        home_pos = nxt_home; target_pos = nxt_tgt;
        model_step();
    endtask

    task automatic wait_done(output int n);
        bit seen;
        seen = 0;
        n = 99;
        for (int i = 1; i <= 40; i++) begin
            if (!seen) begin
                cyc(0, 0, 0, 1);
                if (obs_done) begin
                    n = i;
                    seen = 1;
                end
            end
        end
    endtask

    function automatic pos_t rnd_pos();
        case ($urandom % 4)
            0: return {ROW_W'($urandom), 5'd21};
            1: return {5'd31, COL_W'($urandom % MAZE_COLS)};
            2: return {ROW_W'($urandom), COL_W'($urandom % MAZE_COLS)};
            default: return pos_t'($urandom);
        endcase
    endfunction

    initial begin
        int n, nd;
        bit prev, fr, ft, sg, rn;
        reset_n = 0; frame_tick = 0; start_game = 0; freeze = 0;
        home_pos = '0; target_pos = '0;
        nxt_home = '0; nxt_tgt = '0;
        model_step();
        cyc(0, 0, 0, 0);
        chk("rst_pos", 64'(ghost_pos), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        nxt_home = HOME1;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 1);
        chk("home", 64'(ghost_pos), 64'(HOME1));
        chk("home_busy", 64'(busy), 64'd0);
        chk("home_ovr", 64'(overrun), 64'd0);

        for (int i = 0; i < DIV; i++) cyc(1, 0, 0, 1);
        wait_done(n);
        chk("latency", 64'(n), 64'(RLEN + 1));
        chk("advance", 64'(ghost_pos), 64'(EXP2));

        nxt_home = HOME3;
        nxt_tgt = TGT3;
        cyc(0, 0, 1, 1);
        for (int i = 0; i < DIV; i++) cyc(1, 0, 0, 1);
        wait_done(n);
        chk("edges", 64'(ghost_pos), 64'(EXP3));

        prev = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1, 0, 0, 1);
            if (prev) chk("b2b", 64'(obs_busy), 64'd1);
            prev = obs_done;
        end
        chk("ovr_set", 64'(overrun), 64'd1);

        nxt_tgt = '0;
        cyc(0, 0, 1, 1);
        for (int i = 0; i < DIV; i++) cyc(1, 0, 0, 1);
        nd = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 1);
            nd += int'(obs_done);
        end
        for (int i = 0; i < 30; i++) begin
            cyc(1, 1, 0, 1);
            nd += int'(obs_done);
        end
        chk("frz_done", 64'(nd), 64'd1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        chk("hold4", 64'(obs_busy), 64'd0);
        cyc(0, 0, 0, 1);
        chk("hold5", 64'(obs_busy), 64'd1);
        wait_done(n);

        nxt_home = HOME1;
        cyc(0, 0, 1, 1);
        for (int i = 0; i < DIV; i++) cyc(1, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 1);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0, 1);
            nd += int'(obs_done);
        end
        chk("abort_done", 64'(nd), 64'd0);
        chk("abort_pos", 64'(ghost_pos), 64'(HOME1));
        chk("abort_busy", 64'(busy), 64'd0);

        for (int i = 0; i < DIV; i++) cyc(1, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0, 1);
            nd += int'(obs_done);
        end
        chk("rst_done", 64'(nd), 64'd0);
        chk("rst_pos2", 64'(ghost_pos), 64'd0);

        fr = 0;
        for (int i = 0; i < 4000; i++) begin
            for (int g = 0; g < NG; g++) nxt_home[g*POS_W +: POS_W] = rnd_pos();
            nxt_tgt = PW'({$urandom, $urandom});
            if ($urandom % 20 == 0) fr = !fr;
            ft = ($urandom % 4) != 0;
            sg = ($urandom % 250) == 0;
            rn = ($urandom % 400) != 0;
            cyc(ft, fr, sg, rn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
